// File: rtl/srio_swrite_unpack_mc.sv
// SRIO SWRITE (Ftype 6) unpacker: drops the header beat of each packet and forwards the payload
// on AXI-Stream with TDEST picked by a masked address-table lookup; keeps pkt/drop/err counters.
module srio_swrite_unpack_mc #(
    parameter int unsigned             DATA_WIDTH     = 64,
    parameter int unsigned             NUM_CH         = 4,
    parameter int unsigned             TDEST_WIDTH    = 4,
    parameter bit                      DROP_UNMATCHED = 1'b1,
    parameter logic [TDEST_WIDTH-1:0]  MISS_TDEST     = '1
) (
    input  logic                    AXIS_ACLK,
    input  logic                    AXIS_ARESETN,
    input  logic                    S_AXIS_TVALID,
    output logic                    S_AXIS_TREADY,
    input  logic                    S_AXIS_TLAST,
    input  logic [DATA_WIDTH-1:0]   S_AXIS_TDATA,
    output logic                    M_AXIS_TVALID,
    input  logic                    M_AXIS_TREADY,
    output logic                    M_AXIS_TLAST,
    output logic [DATA_WIDTH-1:0]   M_AXIS_TDATA,
    output logic [TDEST_WIDTH-1:0]  M_AXIS_TDEST,
    output logic                    M_AXIS_TID,
    input  logic [31:0]             cmd,
    input  logic [NUM_CH*32-1:0]    addr_table,
    input  logic [NUM_CH*32-1:0]    addr_mask,
    output logic [31:0]             pkt_cnt,
    output logic [31:0]             drop_cnt,
    output logic [31:0]             err_cnt,
    output logic [1:0]              state
);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StHdr     = 2'd1,
        StPayload = 2'd2,
        StDrop    = 2'd3
    } state_e;

    state_e                   state_q, state_d;
    logic                     full_q, full_d;
    logic [DATA_WIDTH-1:0]    data_q;
    logic                     last_q;
    logic [TDEST_WIDTH-1:0]   tdest_q, tdest_d;
    logic [31:0]              pkt_cnt_q, pkt_cnt_d;
    logic [31:0]              drop_cnt_q, drop_cnt_d;
    logic [31:0]              err_cnt_q, err_cnt_d;

    logic start, soft_rst, cnt_clr, cmd_unused;
    logic s_xfr, m_xfr, d_xfr, m_valid;
    logic hit;
    logic [TDEST_WIDTH-1:0]   hit_idx;
    logic [31:0]              hdr_addr;
    logic pkt_inc, drop_inc, err_inc;

    assign start      = cmd[0];
    assign soft_rst   = cmd[1];
    assign cnt_clr    = cmd[2];
    assign cmd_unused = ^cmd[31:3];
    assign hdr_addr   = data_q[31:0];

    // Scan from the top so the lowest matching index is the one left standing.
    always_comb begin : addr_match
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
            if (((hdr_addr ^ addr_table[32*i +: 32]) & addr_mask[32*i +: 32]) == 32'd0) begin
                hit     = 1'b1;
                hit_idx = TDEST_WIDTH'(i);
            end
        end
    end

    always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin : fsm_reg
        if (!AXIS_ARESETN) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin : fsm_next
        state_d = state_q;
        tdest_d = tdest_q;
        unique case (state_q)
            StIdle: begin
                if (start) state_d = StHdr;
            end
            StHdr: begin
                // A header carrying TLAST is an error and is swallowed without leaving HDR.
                if (full_q && !last_q) begin
                    if (hit) begin
                        tdest_d = hit_idx;
                        state_d = StPayload;
                    end else if (DROP_UNMATCHED) begin
                        state_d = StDrop;
                    end else begin
                        tdest_d = MISS_TDEST;
                        state_d = StPayload;
                    end
                end
            end
            StPayload: begin
                if (m_xfr && last_q) state_d = StHdr;
            end
            StDrop: begin
                if (full_q && last_q) state_d = StHdr;
            end
            default: state_d = StIdle;
        endcase
        if (soft_rst) state_d = StIdle;
    end

    always_comb begin : fsm_out
        m_valid = 1'b0;
        d_xfr   = 1'b0;
        unique case (state_q)
            StIdle:    d_xfr = 1'b0;
            StHdr:     d_xfr = full_q;
            StPayload: begin
                m_valid = full_q;
                d_xfr   = full_q & M_AXIS_TREADY;
            end
            StDrop:    d_xfr = full_q;
            default:   d_xfr = 1'b0;
        endcase
        // Soft reset freezes both sides for its cycle so nothing is transferred or counted.
        if (soft_rst) begin
            m_valid = 1'b0;
            d_xfr   = 1'b0;
        end
    end

    assign m_xfr         = m_valid & M_AXIS_TREADY;
    assign S_AXIS_TREADY = (!full_q | d_xfr) & !soft_rst;
    assign s_xfr         = S_AXIS_TVALID & S_AXIS_TREADY;

    always_comb begin : hold_next
        full_d = full_q;
        if (s_xfr) begin
            full_d = 1'b1;
        end else if (d_xfr) begin
            full_d = 1'b0;
        end
        if (soft_rst) full_d = 1'b0;
    end

    assign pkt_inc  = m_xfr & last_q;
    assign drop_inc = (state_q == StDrop) & d_xfr & last_q;
    assign err_inc  = (state_q == StHdr) & d_xfr & last_q;

    always_comb begin : cnt_next
        pkt_cnt_d  = pkt_cnt_q + 32'(pkt_inc);
        drop_cnt_d = drop_cnt_q + 32'(drop_inc);
        err_cnt_d  = err_cnt_q + 32'(err_inc);
        if (cnt_clr) begin
            pkt_cnt_d  = '0;
            drop_cnt_d = '0;
            err_cnt_d  = '0;
        end
    end

    always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin : datapath_reg
        if (!AXIS_ARESETN) begin
            full_q     <= 1'b0;
            data_q     <= '0;
            last_q     <= 1'b0;
            tdest_q    <= '0;
            pkt_cnt_q  <= '0;
            drop_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            full_q     <= full_d;
            tdest_q    <= tdest_d;
            pkt_cnt_q  <= pkt_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            err_cnt_q  <= err_cnt_d;
            if (s_xfr) begin
                data_q <= S_AXIS_TDATA;
                last_q <= S_AXIS_TLAST;
            end
        end
    end

    assign M_AXIS_TVALID = m_valid;
    assign M_AXIS_TDATA  = data_q;
    assign M_AXIS_TLAST  = last_q & m_valid;
    assign M_AXIS_TDEST  = tdest_q;
    assign M_AXIS_TID    = tdest_q[0];
    assign pkt_cnt       = pkt_cnt_q;
    assign drop_cnt      = drop_cnt_q;
    assign err_cnt       = err_cnt_q;
    assign state         = state_q;

endmodule

// File: tb/tb_srio_swrite_unpack_mc.sv
// Bench for srio_swrite_unpack_mc: table-driven address routing, randomized traffic against a
// packet-level reference model, and hand-written soft/async reset sequences.
module tb_srio_swrite_unpack_mc;

    localparam int NCH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [31:0] cmd;
    logic [31:0] tbl [NCH];
    logic [31:0] msk [NCH];
    logic [NCH*32-1:0] addr_table, addr_mask;

    for (genvar g = 0; g < NCH; g++) begin : g_pack
        assign addr_table[32*g +: 32] = tbl[g];
        assign addr_mask[32*g +: 32]  = msk[g];
    end

    // Instance A: unmatched packets dropped
    logic        s_valid, s_ready, s_last, m_valid, m_ready, m_last, m_tid;
    logic [63:0] s_data, m_data;
    logic [3:0]  m_dest;
    logic [31:0] pkt_cnt, drop_cnt, err_cnt;
    logic [1:0]  state;

    // Instance B: unmatched packets forwarded on MISS_TDEST
    logic        b_s_valid, b_s_ready, b_s_last, b_m_valid, b_m_ready, b_m_last, b_m_tid;
    logic [63:0] b_s_data, b_m_data;
    logic [3:0]  b_m_dest;
    logic [31:0] b_pkt_cnt, b_drop_cnt, b_err_cnt;
    logic [1:0]  b_state;

    srio_swrite_unpack_mc #(.DROP_UNMATCHED(1'b1)) dut (
        .AXIS_ACLK(clk), .AXIS_ARESETN(rst_n),
        .S_AXIS_TVALID(s_valid), .S_AXIS_TREADY(s_ready), .S_AXIS_TLAST(s_last),
        .S_AXIS_TDATA(s_data),
        .M_AXIS_TVALID(m_valid), .M_AXIS_TREADY(m_ready), .M_AXIS_TLAST(m_last),
        .M_AXIS_TDATA(m_data), .M_AXIS_TDEST(m_dest), .M_AXIS_TID(m_tid),
        .cmd(cmd), .addr_table(addr_table), .addr_mask(addr_mask),
        .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt), .err_cnt(err_cnt), .state(state)
    );

    srio_swrite_unpack_mc #(.DROP_UNMATCHED(1'b0)) dut_fwd (
        .AXIS_ACLK(clk), .AXIS_ARESETN(rst_n),
        .S_AXIS_TVALID(b_s_valid), .S_AXIS_TREADY(b_s_ready), .S_AXIS_TLAST(b_s_last),
        .S_AXIS_TDATA(b_s_data),
        .M_AXIS_TVALID(b_m_valid), .M_AXIS_TREADY(b_m_ready), .M_AXIS_TLAST(b_m_last),
        .M_AXIS_TDATA(b_m_data), .M_AXIS_TDEST(b_m_dest), .M_AXIS_TID(b_m_tid),
        .cmd(cmd), .addr_table(addr_table), .addr_mask(addr_mask),
        .pkt_cnt(b_pkt_cnt), .drop_cnt(b_drop_cnt), .err_cnt(b_err_cnt), .state(b_state)
    );

    typedef struct { logic [63:0] data; logic last; } beat_t;
    typedef struct { logic [63:0] data; logic last; logic [3:0] dest; logic tid; } obeat_t;
    typedef struct { logic [31:0] addr; int dest; } vec_t;

    beat_t  src_q[$];
    beat_t  b_src_q[$];
    obeat_t exp_q[$];
    obeat_t b_got[$];
    int     start_cyc[$];
    bit     at_start = 1'b1;
    logic   prev_pend = 1'b0;
    logic [63:0] prev_data;
    int cyc = 0;
    int vpct = 100, rpct = 100;
    int exp_pkt = 0, exp_drop = 0, exp_err = 0;
    int n_checks = 0, n_errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Packet-level reference: first table entry whose masked bits equal the address, else miss.
    function automatic int model_dest(input logic [31:0] a);
        for (int i = 0; i < NCH; i++) begin
            if (((a ^ tbl[i]) & msk[i]) == 32'd0) return i;
        end
        return -1;
    endfunction

    // One clock: sample everything at the falling edge, then drive new inputs just after rising.
    task automatic tick();
        obeat_t e;
        logic s_acc, b_acc;
        @(negedge clk);
        if (prev_pend && !cmd[1] && rst_n)
            check("tvalid_hold", {m_valid, m_data}, {1'b1, prev_data});
        prev_pend = m_valid && !m_ready;
        prev_data = m_data;
        if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_beat: got data 0x%0h, expected no output", m_data);
            end else begin
                e = exp_q.pop_front();
                check("out_beat", {m_data, m_last, m_dest, m_tid}, {e.data, e.last, e.dest, e.tid});
                if (at_start) start_cyc.push_back(cyc);
                at_start = m_last;
            end
        end
        s_acc = s_valid && s_ready;
        b_acc = b_s_valid && b_s_ready;
        if (b_m_valid && b_m_ready) begin
            e.data = b_m_data; e.last = b_m_last; e.dest = b_m_dest; e.tid = b_m_tid;
            b_got.push_back(e);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (s_acc) void'(src_q.pop_front());
        if (!(s_valid && !s_acc)) begin
            if (src_q.size() > 0 && int'($urandom_range(99)) < vpct) begin
                s_valid = 1'b1;
                s_data  = src_q[0].data;
                s_last  = src_q[0].last;
            end else begin
                s_valid = 1'b0;
            end
        end
        m_ready = int'($urandom_range(99)) < rpct;
        if (b_acc) void'(b_src_q.pop_front());
        if (b_src_q.size() > 0) begin
            b_s_valid = 1'b1;
            b_s_data  = b_src_q[0].data;
            b_s_last  = b_src_q[0].last;
        end else begin
            b_s_valid = 1'b0;
        end
    endtask

    // dest < 0: packet is expected to be dropped; n == 0: header-only error packet.
    task automatic send_pkt(input logic [31:0] addr, input int n, input int dest);
        beat_t  b;
        obeat_t o;
        b.data = {$urandom, addr};
        b.last = (n == 0);
        src_q.push_back(b);
        for (int k = 0; k < n; k++) begin
            b.data = {$urandom, $urandom};
            b.last = (k == n - 1);
            src_q.push_back(b);
            if (dest >= 0) begin
                o.data = b.data; o.last = b.last; o.dest = 4'(dest); o.tid = o.dest[0];
                exp_q.push_back(o);
            end
        end
        if (n == 0) exp_err++;
        else if (dest < 0) exp_drop++;
        else exp_pkt++;
    endtask

    task automatic drain();
        int t = 0;
        while ((src_q.size() > 0 || s_valid || exp_q.size() > 0) && t < 20000) begin
            tick();
            t++;
        end
        if (t >= 20000) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain_timeout: %0d beats still expected, required 0", exp_q.size());
            src_q.delete();
            exp_q.delete();
            s_valid = 1'b0;
        end
        repeat (4) tick();
    endtask

    task automatic check_cnts(input string tag);
        check({tag, "_pkt_cnt"}, pkt_cnt, 32'(exp_pkt));
        check({tag, "_drop_cnt"}, drop_cnt, 32'(exp_drop));
        check({tag, "_err_cnt"}, err_cnt, 32'(exp_err));
    endtask

    task automatic clear_cnts();
        cmd[2] = 1'b1;
        tick();
        cmd[2] = 1'b0;
        exp_pkt = 0; exp_drop = 0; exp_err = 0;
        tick();
        check_cnts("clear");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        vec_t vecs[9];
        obeat_t bexp[4];
        beat_t  bb;
        logic [31:0] a;
        int t, i;

        rst_n = 1'b0; cmd = '0;
        s_valid = 1'b0; s_last = 1'b0; s_data = '0; m_ready = 1'b0;
        b_s_valid = 1'b0; b_s_last = 1'b0; b_s_data = '0; b_m_ready = 1'b1;
        tbl = '{32'h100, 32'h200, 32'h300, 32'h400};
        msk = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        repeat (3) @(posedge clk);
        #1;
        check("rst_state", state, 2'd0);
        check("rst_s_ready", s_ready, 1'b1);
        check("rst_m_valid", m_valid, 1'b0);
        check("rst_m_data", m_data, 64'd0);
        check("rst_m_last", m_last, 1'b0);
        check("rst_m_dest", {m_dest, m_tid}, 5'd0);
        check_cnts("rst");
        rst_n = 1'b1;

        // IDLE accepts a single beat and then stalls until start
        send_pkt(32'h300, 8, 2);
        repeat (4) tick();
        check("idle_state", state, 2'd0);
        check("idle_s_ready", s_ready, 1'b0);
        check("idle_m_valid", m_valid, 1'b0);
        check("idle_one_beat", 32'(src_q.size()), 32'd8);
        cmd[0] = 1'b1;
        drain();
        check_cnts("basic");

        // Back-to-back 8-beat packets occupy 9 cycles each
        start_cyc.delete();
        send_pkt(32'h300, 8, 2);
        send_pkt(32'h200, 8, 1);
        drain();
        check("b2b_pkts", 32'(start_cyc.size()), 32'd2);
        if (start_cyc.size() >= 2) check("b2b_period", 32'(start_cyc[1] - start_cyc[0]), 32'd9);
        check_cnts("b2b");

        // Table-driven routing: lowest index wins, masked and full-width compares, misses
        tbl = '{32'h1000, 32'h1234, 32'h300, 32'h400};
        msk = '{32'hFFFF_F000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_FFFF};
        vecs = '{'{32'h0000_1234, 0}, '{32'h0000_1FFF, 0}, '{32'h0000_0300, 2},
                 '{32'h0000_0400, 3}, '{32'h5555_0400, 3}, '{32'h0000_2234, -1},
                 '{32'hABCD_0300, -1}, '{32'h0000_0FFF, -1}, '{32'h0000_DEAD, -1}};
        for (int v = 0; v < 9; v++) send_pkt(vecs[v].addr, 1 + v % 3, vecs[v].dest);
        drain();
        check_cnts("vec");

        // Forwarding variant: a miss goes out on TDEST 0xF
        bb.data = {32'd0, 32'h0000_DEAD}; bb.last = 1'b0;
        b_src_q.push_back(bb);
        for (int k = 0; k < 4; k++) begin
            bb.data = {$urandom, $urandom}; bb.last = (k == 3);
            b_src_q.push_back(bb);
            bexp[k].data = bb.data; bexp[k].last = bb.last; bexp[k].dest = 4'hF; bexp[k].tid = 1'b1;
        end
        t = 0;
        while (b_got.size() < 4 && t < 50) begin tick(); t++; end
        check("fwd_beats", 32'(b_got.size()), 32'd4);
        for (int k = 0; k < 4 && k < b_got.size(); k++)
            check("fwd_beat", {b_got[k].data, b_got[k].last, b_got[k].dest, b_got[k].tid},
                  {bexp[k].data, bexp[k].last, bexp[k].dest, bexp[k].tid});
        repeat (2) tick();
        check("fwd_pkt_cnt", {b_pkt_cnt, b_drop_cnt}, {32'd1, 32'd0});

        // Header-only packet then a normal 2-beat packet
        send_pkt(32'h300, 0, 0);
        send_pkt(32'h300, 2, 2);
        drain();
        check_cnts("hdr_only");

        // Random handshakes; start dropped mid-run must not matter
        clear_cnts();
        cmd[0] = 1'b0;
        vpct = 60; rpct = 50;
        for (int p = 0; p < 100; p++) begin
            i = int'($urandom_range(NCH - 1));
            a = tbl[i];
            if (i == 0) a = a | $urandom_range(4095);
            if (i == 3) a = a | ($urandom & 32'hFFFF_0000);
            send_pkt(a, 1 + int'($urandom_range(5)), model_dest(a));
        end
        drain();
        check("rand_pkt_cnt_100", pkt_cnt, 32'd100);
        check_cnts("rand_hit");
        for (int p = 0; p < 40; p++) begin
            a = ($urandom_range(2) == 0) ? $urandom : tbl[$urandom_range(NCH - 1)];
            send_pkt(a, int'($urandom_range(5)), model_dest(a));
        end
        drain();
        check_cnts("rand_mix");

        // Soft reset during payload beat 3 of 6
        vpct = 100; rpct = 100;
        send_pkt(32'h300, 6, 2);
        t = 0;
        while (exp_q.size() > 4 && t < 100) begin tick(); t++; end
        cmd[1] = 1'b1;
        tick();
        cmd[1] = 1'b0;
        src_q.delete(); exp_q.delete(); s_valid = 1'b0;
        exp_pkt--;
        at_start = 1'b1; prev_pend = 1'b0;
        check("srst_state", state, 2'd0);
        check("srst_m_valid", m_valid, 1'b0);
        check_cnts("srst_kept");
        repeat (3) tick();
        check("srst_stay_idle", state, 2'd0);
        cmd[0] = 1'b1;
        send_pkt(32'h400, 3, 3);
        drain();
        check_cnts("srst_after");
        clear_cnts();

        // Async reset mid-packet
        send_pkt(32'h300, 6, 2);
        t = 0;
        while (exp_q.size() > 3 && t < 100) begin tick(); t++; end
        rst_n = 1'b0;
        #1;
        check("arst_m_valid", m_valid, 1'b0);
        check("arst_state", state, 2'd0);
        src_q.delete(); exp_q.delete(); s_valid = 1'b0;
        exp_pkt = 0; exp_drop = 0; exp_err = 0;
        at_start = 1'b1; prev_pend = 1'b0;
        check_cnts("arst");
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (6) tick();
        check("arst_no_output", m_valid, 1'b0);
        check("arst_hdr_state", state, 2'd1);
        check_cnts("arst_after");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
